costas_gear_ctrl: RTL and testbench
===================================

Name: costas_gear_ctrl

Overview:
- Loop-bandwidth scheduler for the Costas loop NCO phase stage.
- Consumes the loop-filter error stream and forwards it, registered and gated, as the NCO feedback stream.
- Sequences the NCO feedback right-shift from a wide acquisition gear, through stepwise narrowing, to a narrow tracking gear.
- Drops back to acquisition on loss of lock; reports lock state.

Parameters:
- WIDTH, 16: error/feedback sample width (signed).
- SHIFT_ACQ, 2: feedback shift in acquisition (wide bandwidth).
- SHIFT_TRK, 6: feedback shift in tracking; SHIFT_ACQ < SHIFT_TRK <= 15 required.
- LOCK_THRESH, 1024: |err| strictly below this counts as a good sample.
- LOCK_COUNT, 256: consecutive good samples to leave ACQUIRE.
- STEP_DWELL, 128: valid samples per gear step in NARROW.
- UNLOCK_COUNT, 64: consecutive bad samples to declare loss of lock.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- enable, input, 1: loop enable; low forces IDLE.
- err_tdata, input, WIDTH signed: loop-filter error.
- err_tvalid, input, 1: error valid.
- feedback_tdata, output reg, WIDTH signed: error forwarded to the NCO phase stage.
- feedback_tvalid, output reg, 1: feedback valid to the NCO phase stage.
- feedback_shift, output reg, 4: right-shift configuration to the NCO phase stage.
- locked, output reg, 1: high only in TRACK.
- state, output reg, 2: 0 IDLE, 1 ACQUIRE, 2 NARROW, 3 TRACK.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and wins over all other inputs.
- Reset values: state=IDLE, feedback_shift=SHIFT_ACQ, feedback_tdata=0, feedback_tvalid=0, locked=0, all counters 0.
- Abs: |err| uses saturating absolute value; the most-negative code maps to 2^(WIDTH-1)-1.
- good = err_tvalid && |err| < LOCK_THRESH. bad = err_tvalid && !good.
- Counters advance only on err_tvalid cycles; non-valid cycles hold every counter.
- Forwarding: feedback_tdata <= err_tdata and feedback_tvalid <= err_tvalid && state!=IDLE. Latency 1 cycle.
- In IDLE, feedback_tvalid=0 so the NCO runs at its free frequency.
- feedback_shift, locked and state are registered and change in the cycle after the deciding sample.
- The forwarded sample that triggers a transition still carries the old feedback_shift.
- IDLE:
  - shift=SHIFT_ACQ.
  - enable=1 -> ACQUIRE, all counters cleared.
- ACQUIRE:
  - shift=SHIFT_ACQ.
  - good_cnt increments on good and clears on bad.
  - good_cnt reaching LOCK_COUNT (on the LOCK_COUNT-th consecutive good) -> NARROW, shift=SHIFT_ACQ+1, counters cleared.
- NARROW:
  - dwell_cnt counts valid samples and bad_cnt counts consecutive bad.
  - dwell_cnt reaching STEP_DWELL -> shift+1, dwell_cnt cleared.
  - If the new shift equals SHIFT_TRK -> TRACK, locked=1.
  - bad_cnt reaching UNLOCK_COUNT -> ACQUIRE, shift=SHIFT_ACQ, counters cleared.
  - If a step and an unlock occur on the same sample, unlock wins.
- TRACK:
  - shift=SHIFT_TRK, locked=1.
  - bad_cnt reaching UNLOCK_COUNT -> ACQUIRE, locked=0, shift=SHIFT_ACQ.
- enable=0 in any state -> IDLE next cycle, shift=SHIFT_ACQ, locked=0, counters cleared. This has priority over all other transitions except rst.
- SHIFT_TRK = SHIFT_ACQ+1: ACQUIRE exit goes directly to TRACK.
- Counter widths are sized with $clog2 of the respective parameter plus 1; counters never wrap.

Optional Feature:
- Macro: COSTAS_GEAR_STATS_EN.
- Defined:
  - Adds output unlock_events [15:0], a saturating count (stops at 65535) of TRACK/NARROW -> ACQUIRE transitions.
  - Adds output lock_cycles [31:0], counting clk cycles since the last ACQUIRE entry, frozen on reaching TRACK.
  - Both outputs reset to 0.
- Undefined: neither port nor any stats logic exists; the core behaviour is identical.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then enable=0 with err_tvalid=1, err=100 -> feedback_tvalid=0, feedback_shift=2, state=0, locked=0.
- Acquire-to-track: enable=1, continuous err=±200 valid -> NARROW after the 256th sample with shift=3; shift steps every 128 samples to 4, 5, 6; TRACK/locked=1 one cycle after the 256+3*128=640th sample.
- Counter holds on invalid: same stimulus with err_tvalid toggling every other cycle -> identical transitions at identical valid-sample counts; feedback_tvalid mirrors err_tvalid delayed by 1.
- Loss of lock: in TRACK, 63 samples err=5000 then 1 good then 64 bad -> stays TRACK through the first burst; ACQUIRE, shift=2, locked=0 after the 64th consecutive bad.
- Saturation/threshold: err=-32768 counts as bad (abs=32767); err=1023 counts as good, err=1024 as bad; err=-1024 as bad.
- Mid-operation enable drop and reset: in NARROW, enable=0 -> IDLE next cycle, shift=2. Re-enter NARROW, assert rst -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/costas_gear_ctrl.sv
// Costas loop bandwidth scheduler: forwards the loop-filter error to the NCO and steps its feedback
// shift from acquisition to tracking gear. Optional stats outputs are enabled by COSTAS_GEAR_STATS_EN.
module costas_gear_ctrl #(
  parameter int WIDTH        = 16,
  parameter int SHIFT_ACQ    = 2,
  parameter int SHIFT_TRK    = 6,
  parameter int LOCK_THRESH  = 1024,
  parameter int LOCK_COUNT   = 256,
  parameter int STEP_DWELL   = 128,
  parameter int UNLOCK_COUNT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] err_tdata,
  input  logic                    err_tvalid,
  output logic signed [WIDTH-1:0] feedback_tdata,
  output logic                    feedback_tvalid,
  output logic [3:0]              feedback_shift,
  output logic                    locked,
  output logic [1:0]              state
`ifdef COSTAS_GEAR_STATS_EN
  ,
  output logic [15:0]             unlock_events,
  output logic [31:0]             lock_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACQ = 2'd1, S_NARROW = 2'd2, S_TRACK = 2'd3} state_t;

  localparam int GOOD_W  = $clog2(LOCK_COUNT) + 1;
  localparam int DWELL_W = $clog2(STEP_DWELL) + 1;
  localparam int BAD_W   = $clog2(UNLOCK_COUNT) + 1;

  localparam logic [GOOD_W-1:0]  GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(STEP_DWELL - 1);
  localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(UNLOCK_COUNT - 1);
  localparam logic [3:0]         SHIFT_ACQ_L = 4'(SHIFT_ACQ);
  localparam logic [3:0]         SHIFT_TRK_L = 4'(SHIFT_TRK);
  localparam logic [WIDTH:0]     THRESH_L    = (WIDTH+1)'(LOCK_THRESH);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                    state_q, state_d;
  logic [3:0]                shift_q, shift_d;
  logic [GOOD_W-1:0]         good_cnt_q, good_cnt_d;
  logic [DWELL_W-1:0]        dwell_cnt_q, dwell_cnt_d;
  logic [BAD_W-1:0]          bad_cnt_q, bad_cnt_d;
  logic signed [WIDTH-1:0]   fb_data_q;
  logic                      fb_valid_q;
  logic [WIDTH-1:0]          err_abs;
  logic                      good;

  // Saturating magnitude: the most-negative code has no positive twin
  always_comb begin
    if (err_tdata == MOST_NEG) begin
      err_abs = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (err_tdata[WIDTH-1]) begin
      err_abs = $unsigned(-err_tdata);
    end else begin
      err_abs = $unsigned(err_tdata);
    end
  end

  assign good = err_tvalid && ({1'b0, err_abs} < THRESH_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= SHIFT_ACQ_L;
      good_cnt_q  <= '0;
      dwell_cnt_q <= '0;
      bad_cnt_q   <= '0;
      fb_data_q   <= '0;
      fb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      good_cnt_q  <= good_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      fb_data_q   <= err_tdata;
      fb_valid_q  <= err_tvalid && (state_q != S_IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    good_cnt_d  = good_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    if (!enable) begin
      state_d     = S_IDLE;
      shift_d     = SHIFT_ACQ_L;
      good_cnt_d  = '0;
      dwell_cnt_d = '0;
      bad_cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_ACQ;
          shift_d     = SHIFT_ACQ_L;
          good_cnt_d  = '0;
          dwell_cnt_d = '0;
          bad_cnt_d   = '0;
        end
        S_ACQ: begin
          if (err_tvalid) begin
            if (!good) begin
              good_cnt_d = '0;
            end else if (good_cnt_q == GOOD_LAST) begin
              good_cnt_d  = '0;
              dwell_cnt_d = '0;
              bad_cnt_d   = '0;
              shift_d     = SHIFT_ACQ_L + 4'd1;
              state_d     = (SHIFT_ACQ_L + 4'd1 == SHIFT_TRK_L) ? S_TRACK : S_NARROW;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          // NARROW and TRACK share loss-of-lock detection; unlock beats a gear step
          if (err_tvalid) begin
            bad_cnt_d = good ? '0 : bad_cnt_q + 1'b1;
            if (!good && bad_cnt_q == BAD_LAST) begin
              state_d     = S_ACQ;
              shift_d     = SHIFT_ACQ_L;
              good_cnt_d  = '0;
              dwell_cnt_d = '0;
              bad_cnt_d   = '0;
            end else if (state_q == S_NARROW) begin
              dwell_cnt_d = dwell_cnt_q + 1'b1;
              if (dwell_cnt_q == DWELL_LAST) begin
                dwell_cnt_d = '0;
                shift_d     = shift_q + 4'd1;
                if (shift_q + 4'd1 == SHIFT_TRK_L) begin
                  state_d = S_TRACK;
                end
              end
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    state           = state_q;
    feedback_shift  = shift_q;
    locked          = (state_q == S_TRACK);
    feedback_tdata  = fb_data_q;
    feedback_tvalid = fb_valid_q;
  end

`ifdef COSTAS_GEAR_STATS_EN
  logic [15:0] unlock_events_q;
  logic [31:0] lock_cycles_q;
  logic        unlock_evt;

  assign unlock_evt = ((state_q == S_NARROW) || (state_q == S_TRACK)) && (state_d == S_ACQ);

  // lock_cycles restarts on every ACQUIRE entry and freezes once TRACK is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      unlock_events_q <= '0;
      lock_cycles_q   <= '0;
    end else begin
      if (unlock_evt && (unlock_events_q != 16'hFFFF)) begin
        unlock_events_q <= unlock_events_q + 16'd1;
      end
      if ((state_d == S_ACQ) && (state_q != S_ACQ)) begin
        lock_cycles_q <= '0;
      end else if ((state_q == S_ACQ) || (state_q == S_NARROW)) begin
        lock_cycles_q <= lock_cycles_q + 32'd1;
      end
    end
  end

  assign unlock_events = unlock_events_q;
  assign lock_cycles   = lock_cycles_q;
`endif

endmodule

// File: tb/tb_costas_gear_ctrl.sv
// Self-checking bench for costas_gear_ctrl: reset/idle table, gear-sequencing scenarios,
// and randomized traffic checked against a sample-count reference model.
module tb_costas_gear_ctrl;
  localparam int SHIFT_ACQ    = 2;
  localparam int SHIFT_TRK    = 6;
  localparam int LOCK_THRESH  = 1024;
  localparam int LOCK_COUNT   = 256;
  localparam int STEP_DWELL   = 128;
  localparam int UNLOCK_COUNT = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               err_tvalid = 1'b0;
  logic signed [15:0] err_tdata = '0;
  logic signed [15:0] feedback_tdata;
  logic               feedback_tvalid;
  logic [3:0]         feedback_shift;
  logic               locked;
  logic [1:0]         state;
`ifdef COSTAS_GEAR_STATS_EN
  logic [15:0]        unlock_events;
  logic [31:0]        lock_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  costas_gear_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable),
    .err_tdata(err_tdata), .err_tvalid(err_tvalid),
    .feedback_tdata(feedback_tdata), .feedback_tvalid(feedback_tvalid),
    .feedback_shift(feedback_shift), .locked(locked), .state(state)
`ifdef COSTAS_GEAR_STATS_EN
    , .unlock_events(unlock_events), .lock_cycles(lock_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: tracks run lengths and samples spent narrowing; gear derived by division
  int m_state = 0, m_shift = SHIFT_ACQ, m_good_run = 0, m_bad_run = 0, m_narrow_n = 0, m_data = 0;
  bit m_tv = 1'b0;

  function automatic int sat_abs(input int e);
    if (e == -32768) return 32767;
    return (e < 0) ? -e : e;
  endfunction

  task automatic m_clear();
    m_good_run = 0; m_bad_run = 0; m_narrow_n = 0; m_shift = SHIFT_ACQ;
  endtask

  task automatic model_step(input bit r, input bit en, input bit v, input int e);
    bit g;
    g = v && (sat_abs(e) < LOCK_THRESH);
    if (r) begin
      m_data = 0; m_tv = 1'b0; m_state = 0; m_clear();
    end else begin
      m_data = e;
      m_tv = v && (m_state != 0);
      if (!en) begin
        m_state = 0; m_clear();
      end else if (m_state == 0) begin
        m_state = 1; m_clear();
      end else if (v && m_state == 1) begin
        m_good_run = g ? m_good_run + 1 : 0;
        if (m_good_run == LOCK_COUNT) begin
          m_clear();
          m_shift = SHIFT_ACQ + 1;
          m_state = (m_shift == SHIFT_TRK) ? 3 : 2;
        end
      end else if (v) begin
        m_bad_run = g ? 0 : m_bad_run + 1;
        if (m_bad_run == UNLOCK_COUNT) begin
          m_state = 1; m_clear();
        end else if (m_state == 2) begin
          m_narrow_n++;
          m_shift = SHIFT_ACQ + 1 + m_narrow_n / STEP_DWELL;
          if (m_shift == SHIFT_TRK) m_state = 3;
        end
      end
    end
  endtask

  task automatic compare_model();
    vectors++;
    if ($signed(feedback_tdata) !== m_data || feedback_tvalid !== m_tv ||
        int'(feedback_shift) != m_shift || int'(state) != m_state ||
        locked !== (m_state == 3)) begin
      miscompares++;
      $display("FAIL model t=%0t: got st=%0d sh=%0d lk=%0b tv=%0b d=%0d, want st=%0d sh=%0d lk=%0b tv=%0b d=%0d",
               $time, state, feedback_shift, locked, feedback_tvalid, feedback_tdata,
               m_state, m_shift, (m_state == 3), m_tv, m_data);
    end
  endtask

  task automatic cycle(input bit r, input bit en, input bit v, input int e);
    rst = r; enable = en; err_tvalid = v; err_tdata = 16'(e);
    @(posedge clk);
    model_step(r, en, v, e);
    #1;
    compare_model();
  endtask

  task automatic expect_out(input string name, input int st, input int sh, input bit lk);
    vectors++;
    $display("check %s: state=%0d shift=%0d locked=%0b", name, state, feedback_shift, locked);
    if (int'(state) != st || int'(feedback_shift) != sh || locked !== lk) begin
      miscompares++;
      $display("FAIL %s: got st=%0d sh=%0d lk=%0b, want st=%0d sh=%0d lk=%0b",
               name, state, feedback_shift, locked, st, sh, lk);
    end
  endtask

  task automatic expect_fb(input string name, input bit tv, input int d);
    vectors++;
    if (feedback_tvalid !== tv || $signed(feedback_tdata) !== d) begin
      miscompares++;
      $display("FAIL %s: got tv=%0b d=%0d, want tv=%0b d=%0d", name, feedback_tvalid, feedback_tdata, tv, d);
    end
  endtask

  task automatic gear_milestones(input string tag, input int n);
    if (n == 255) expect_out({tag, "_acq255"}, 1, 2, 0);
    if (n == 256) expect_out({tag, "_narrow256"}, 2, 3, 0);
    if (n == 383) expect_out({tag, "_g3_383"}, 2, 3, 0);
    if (n == 384) expect_out({tag, "_g4_384"}, 2, 4, 0);
    if (n == 512) expect_out({tag, "_g5_512"}, 2, 5, 0);
    if (n == 639) expect_out({tag, "_g5_639"}, 2, 5, 0);
    if (n == 640) expect_out({tag, "_track640"}, 3, 6, 1);
  endtask

  task automatic reach_track();
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    for (int n = 1; n <= 640; n++) cycle(0, 1, 1, (n % 2) ? 200 : -200);
    expect_out("track_reached", 3, 6, 1);
  endtask

  task automatic bad_burst(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 1, 5000);
  endtask

  typedef struct {
    bit r; bit en; bit v; int err;
    bit exp_tv; int exp_data; int exp_shift; int exp_state; bit exp_lk;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int regime;
    tbl[0] = '{1, 0, 1, 100,    0, 0,      2, 0, 0};
    tbl[1] = '{1, 1, 1, 55,     0, 0,      2, 0, 0};
    tbl[2] = '{1, 1, 1, 66,     0, 0,      2, 0, 0};
    tbl[3] = '{0, 0, 1, 100,    0, 100,    2, 0, 0};
    tbl[4] = '{0, 0, 1, -5,     0, -5,     2, 0, 0};
    tbl[5] = '{0, 1, 1, 7,      0, 7,      2, 1, 0};
    tbl[6] = '{0, 1, 1, -32768, 1, -32768, 2, 1, 0};
    tbl[7] = '{0, 1, 0, 3,      0, 3,      2, 1, 0};
    tbl[8] = '{0, 0, 1, 9,      1, 9,      2, 0, 0};
    tbl[9] = '{0, 0, 1, -77,    0, -77,    2, 0, 0};

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].en, tbl[i].v, tbl[i].err);
      vectors++;
      $display("vec %0d: rst=%0b en=%0b v=%0b err=%0d -> tv=%0b d=%0d sh=%0d st=%0d lk=%0b", i,
               tbl[i].r, tbl[i].en, tbl[i].v, tbl[i].err, feedback_tvalid, feedback_tdata,
               feedback_shift, state, locked);
      if (feedback_tvalid !== tbl[i].exp_tv || $signed(feedback_tdata) !== tbl[i].exp_data ||
          int'(feedback_shift) != tbl[i].exp_shift || int'(state) != tbl[i].exp_state ||
          locked !== tbl[i].exp_lk) begin
        miscompares++;
        $display("FAIL tbl[%0d]: got tv=%0b d=%0d sh=%0d st=%0d lk=%0b, want tv=%0b d=%0d sh=%0d st=%0d lk=%0b",
                 i, feedback_tvalid, feedback_tdata, feedback_shift, state, locked,
                 tbl[i].exp_tv, tbl[i].exp_data, tbl[i].exp_shift, tbl[i].exp_state, tbl[i].exp_lk);
      end
    end

    // Continuous good traffic from IDLE through every gear into TRACK
    cycle(0, 1, 0, 0);
    expect_out("idle_to_acq", 1, 2, 0);
    for (int n = 1; n <= 640; n++) begin
      cycle(0, 1, 1, (n % 2) ? 200 : -200);
      gear_milestones("cont", n);
    end

    // Loss of lock: 63 bad tolerated, a good sample resets the run, 64 bad unlock
    bad_burst(63);
    expect_out("trk_63bad", 3, 6, 1);
    cycle(0, 1, 1, 10);
    expect_out("trk_good_reset", 3, 6, 1);
    bad_burst(63);
    expect_out("trk_63bad_again", 3, 6, 1);
    bad_burst(1);
    expect_out("unlock_64", 1, 2, 0);

    // Threshold and saturation boundaries, probed against the unlock run
    reach_track();
    bad_burst(63);
    cycle(0, 1, 1, 1023);
    expect_out("good_1023", 3, 6, 1);
    bad_burst(63);
    cycle(0, 1, 1, -32768);
    expect_out("bad_min_neg", 1, 2, 0);
    reach_track();
    bad_burst(63);
    cycle(0, 1, 1, 1024);
    expect_out("bad_1024", 1, 2, 0);
    reach_track();
    bad_burst(63);
    cycle(0, 1, 1, -1024);
    expect_out("bad_neg1024", 1, 2, 0);

    // Valid toggling: transitions land on the same valid-sample counts
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    for (int n = 1; n <= 640; n++) begin
      cycle(0, 1, 1, (n % 2) ? 200 : -200);
      expect_fb("tgl_fb_valid", 1, (n % 2) ? 200 : -200);
      gear_milestones("tgl", n);
      cycle(0, 1, 0, 9999);
      expect_fb("tgl_fb_gap", 0, 9999);
      gear_milestones("tglhold", n);
    end

    // Enable drop in NARROW, then reset in NARROW
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    for (int n = 1; n <= 266; n++) cycle(0, 1, 1, 300);
    expect_out("narrow_before_drop", 2, 3, 0);
    cycle(0, 0, 1, 300);
    expect_out("enable_drop", 0, 2, 0);
    cycle(0, 1, 0, 0);
    for (int n = 1; n <= 266; n++) cycle(0, 1, 1, -300);
    expect_out("narrow_before_rst", 2, 3, 0);
    cycle(1, 1, 1, 300);
    expect_out("rst_in_narrow", 0, 2, 0);
    expect_fb("rst_fb", 0, 0);

    // Randomized traffic in regimes: clean, sparse faults, heavy faults
    regime = 0;
    for (int c = 0; c < 4000; c++) begin
      bit r, en, v;
      int e, pick;
      if (c % 600 == 0) begin
        regime = $urandom_range(0, 3);
        $display("random segment %0d: regime=%0d state=%0d shift=%0d", c / 600, regime, state, feedback_shift);
      end
      r = ($urandom_range(0, 999) == 0);
      en = ($urandom_range(0, 299) != 0);
      v = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 99);
      if (regime <= 1 || (regime == 2 && pick >= 3) || (regime == 3 && pick >= 90)) begin
        e = int'($urandom_range(0, 2046)) - 1023;
      end else begin
        case ($urandom_range(0, 3))
          0: e = 1024;
          1: e = -1024;
          2: e = -32768;
          default: e = int'($urandom_range(1024, 32767)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
        endcase
      end
      cycle(r, en, v, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
